// File: rtl/alu_unit_pkg.sv
// alu_unit_pkg: shared definitions for the integer functional units.
//   - Datapath/tag widths (DATA_W, PREG_W) and the physical register tag type.
//   - RISC-V opcode / funct3 / funct7 field constants the ALU decodes.
//   - Reservation-station and ROB row typedefs that share the tag width.
//   - alu_op_e plus decode_op(): maps raw instruction fields to an ALU operation.
package alu_unit_pkg;

  localparam int DATA_W = 32;
  localparam int PREG_W = 6;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRA = 3'b101;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Rows held by the reservation stations and reorder buffer; both carry the
  // destination tag, so the width lives here with the ALU constants.
  typedef struct packed {
    logic       valid;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    data_t      src1;
    data_t      src2;
    preg_t      dest;
  } rs_row_t;

  typedef struct packed {
    logic  valid;
    logic  done;
    preg_t dest;
  } rob_row_t;

  typedef enum logic [2:0] {
    ALU_NONE,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_XOR,
    ALU_SRA
  } alu_op_e;

  // Unrecognised field combinations decode to ALU_NONE, which yields zero.
  function automatic alu_op_e decode_op(input logic [6:0] opcode,
                                        input logic [2:0] func3,
                                        input logic [6:0] func7);
    alu_op_e op;
    op = ALU_NONE;
    case (opcode)
      OP_IMM: begin
        if (func3 == F3_ADD)      op = ALU_ADD;
        else if (func3 == F3_AND) op = ALU_AND;
      end
      OP_REG: begin
        case (func3)
          F3_ADD: begin
            if (func7 == F7_BASE)     op = ALU_ADD;
            else if (func7 == F7_ALT) op = ALU_SUB;
          end
          F3_XOR:  op = ALU_XOR;
          F3_SRA:  if (func7 == F7_ALT) op = ALU_SRA;
          default: op = ALU_NONE;
        endcase
      end
      // Address generation: base plus already-extended offset.
      OP_LOAD, OP_STORE: op = ALU_ADD;
      default: op = ALU_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_unit_if.sv
// alu_unit_if: fire/result bundle between dispatch and an integer functional unit.
//   master (dispatch): drives in_valid, opcode, func3, func7, src1, src2, dest_in;
//                      receives out_valid, dest_out, result.
//   slave  (unit):     the reverse.
interface alu_unit_if;
  import alu_unit_pkg::*;

  logic              in_valid;
  logic [6:0]        opcode;
  logic [2:0]        func3;
  logic [6:0]        func7;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic [PREG_W-1:0] dest_in;
  logic              out_valid;
  logic [PREG_W-1:0] dest_out;
  logic [DATA_W-1:0] result;

  modport master (
    output in_valid, opcode, func3, func7, src1, src2, dest_in,
    input  out_valid, dest_out, result
  );

  modport slave (
    input  in_valid, opcode, func3, func7, src1, src2, dest_in,
    output out_valid, dest_out, result
  );
endinterface

// File: rtl/alu_unit_core.sv
// alu_core: purely combinational decode plus datapath.
//   i_opcode/i_func3/i_func7 : instruction fields of the fired op
//   i_src1/i_src2            : operands (src2 may be a pre-extended immediate)
//   o_result                 : computed value, modulo 2^DATA_W; zero if unrecognised
module alu_core
  import alu_unit_pkg::*;
(
  input  logic [6:0]        i_opcode,
  input  logic [2:0]        i_func3,
  input  logic [6:0]        i_func7,
  input  logic [DATA_W-1:0] i_src1,
  input  logic [DATA_W-1:0] i_src2,
  output logic [DATA_W-1:0] o_result
);

  alu_op_e w_op;

  always_comb begin
    w_op     = decode_op(i_opcode, i_func3, i_func7);
    o_result = '0;
    case (w_op)
      ALU_ADD: o_result = i_src1 + i_src2;
      ALU_SUB: o_result = i_src1 - i_src2;
      ALU_AND: o_result = i_src1 & i_src2;
      ALU_XOR: o_result = i_src1 ^ i_src2;
      // Only the low five bits of the shift amount matter.
      ALU_SRA: o_result = $signed(i_src1) >>> i_src2[4:0];
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// alu_unit: registered integer functional unit, one-cycle latency, no stalls.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset; clears out_valid, result, dest_out
//   bus : alu_unit_if.slave -- fire inputs in, tagged result out
// out_valid tracks in_valid every cycle; result and dest_out only load on a
// fired op and otherwise hold their last value.
module alu_unit
  import alu_unit_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  alu_unit_if.slave bus
);

  logic [DATA_W-1:0] w_result;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_result;
  logic [PREG_W-1:0] r_dest;

  alu_core u_core (
    .i_opcode (bus.opcode),
    .i_func3  (bus.func3),
    .i_func7  (bus.func7),
    .i_src1   (bus.src1),
    .i_src2   (bus.src2),
    .o_result (w_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_dest      <= '0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_result <= w_result;
        r_dest   <= bus.dest_in;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.dest_out  = r_dest;

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed plus randomized checking of alu_unit against an
// arithmetic reference model of the instruction semantics.
module tb_alu_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  logic        exp_valid;
  logic [31:0] exp_result;
  logic [5:0]  exp_dest;

  alu_unit_if bus ();

  alu_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running, want done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  // Reference semantics: plain 64-bit arithmetic reduced modulo 2^32; the
  // arithmetic shift is a floor division by a power of two.
  function automatic logic [31:0] ref_result(input logic [6:0] op, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] t;
    longint      sa, p, q;
    int          sh;
    t = 64'd0;
    if (op == 7'b0000011 || op == 7'b0100011 ||
        (op == 7'b0010011 && f3 == 3'd0) ||
        (op == 7'b0110011 && f3 == 3'd0 && f7 == 7'd0))
      t = (64'(a) + 64'(b)) % 64'h1_0000_0000;
    else if (op == 7'b0010011 && f3 == 3'd7)
      t = 64'(a & b);
    else if (op == 7'b0110011 && f3 == 3'd0 && f7 == 7'h20)
      t = (64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000;
    else if (op == 7'b0110011 && f3 == 3'd4)
      t = 64'(a ^ b);
    else if (op == 7'b0110011 && f3 == 3'd5 && f7 == 7'h20) begin
      sa = longint'($signed(a));
      sh = int'(b % 32);
      p  = longint'(1) << sh;
      if (sa >= 0) q = sa / p;
      else         q = -((-sa + p - 1) / p);
      t = 64'(q);
    end
    return t[31:0];
  endfunction

  // Drives one cycle of stimulus, advances the model and checks all outputs.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] a, input logic [31:0] b, input logic [5:0] d);
    @(negedge clk);
    rst          = r;
    bus.in_valid = v;
    bus.opcode   = op;
    bus.func3    = f3;
    bus.func7    = f7;
    bus.src1     = a;
    bus.src2     = b;
    bus.dest_in  = d;
    @(posedge clk);
    #1;
    if (r) begin
      exp_valid  = 1'b0;
      exp_result = 32'd0;
      exp_dest   = 6'd0;
    end else begin
      exp_valid = v;
      if (v) begin
        exp_result = ref_result(op, f3, f7, a, b);
        exp_dest   = d;
      end
    end
    $display("%0t %s rst=%0b v=%0b op=%b f3=%b f7=%b a=%h b=%h d=%0d -> ov=%0b res=%h dest=%0d",
             $time, tag, r, v, op, f3, f7, a, b, d,
             bus.out_valid, bus.result, bus.dest_out);
    check({tag, ".valid"},  32'(bus.out_valid), 32'(exp_valid));
    check({tag, ".result"}, bus.result, exp_result);
    check({tag, ".dest"},   32'(bus.dest_out), 32'(exp_dest));
  endtask

  localparam logic [6:0] T_IMM = 7'b0010011, T_REG = 7'b0110011, T_LD = 7'b0000011,
                         T_ST = 7'b0100011;

  initial begin
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [31:0] a, b;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.opcode = '0; bus.func3 = '0; bus.func7 = '0;
    bus.src1 = '0; bus.src2 = '0; bus.dest_in = '0;

    // Reset dominates a fired op.
    step("rst0", 1, 1, T_REG, 3'd0, 7'd0, 32'd5, 32'd7, 6'd33);
    step("rst1", 1, 1, T_REG, 3'd0, 7'd0, 32'd5, 32'd7, 6'd33);
    step("add", 0, 1, T_REG, 3'd0, 7'd0, 32'd5, 32'd7, 6'd33);
    check("add.lit", bus.result, 32'h0000000C);
    check("add.dlit", 32'(bus.dest_out), 32'd33);
    step("sub", 0, 1, T_REG, 3'd0, 7'h20, 32'd5, 32'd7, 6'd1);
    check("sub.lit", bus.result, 32'hFFFFFFFE);
    step("subwrap", 0, 1, T_REG, 3'd0, 7'h20, 32'h80000000, 32'd1, 6'd2);
    check("subwrap.lit", bus.result, 32'h7FFFFFFF);
    step("addi", 0, 1, T_IMM, 3'd0, 7'h55, 32'hFFFFFFFF, 32'd1, 6'd3);
    check("addi.lit", bus.result, 32'h00000000);
    step("andi", 0, 1, T_IMM, 3'd7, 7'd0, 32'h000000FF, 32'h000000F0, 6'd4);
    check("andi.lit", bus.result, 32'h000000F0);
    step("xor", 0, 1, T_REG, 3'd4, 7'h20, 32'hAAAA5555, 32'hFFFF0000, 6'd5);
    check("xor.lit", bus.result, 32'h55555555);
    step("sra", 0, 1, T_REG, 3'd5, 7'h20, 32'h80000000, 32'd4, 6'd6);
    check("sra.lit", bus.result, 32'hF8000000);
    step("sra5", 0, 1, T_REG, 3'd5, 7'h20, 32'h40000000, 32'h24, 6'd7);
    check("sra5.lit", bus.result, 32'h04000000);
    step("lw", 0, 1, T_LD, 3'd2, 7'h7F, 32'h100, 32'h10, 6'd8);
    check("lw.lit", bus.result, 32'h00000110);
    step("sw", 0, 1, T_ST, 3'd2, 7'h00, 32'h1000, 32'hFFFFFFFC, 6'd10);
    check("sw.lit", bus.result, 32'h00000FFC);
    step("branch", 0, 1, 7'b1100011, 3'd0, 7'd0, 32'd9, 32'd9, 6'd11);
    check("branch.lit", bus.result, 32'h0);
    check("branch.vlit", 32'(bus.out_valid), 32'd1);

    // Back-to-back ops, each with its own tag.
    step("b2b.add", 0, 1, T_REG, 3'd0, 7'd0, 32'd100, 32'd23, 6'd20);
    step("b2b.xor", 0, 1, T_REG, 3'd4, 7'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 6'd21);
    step("b2b.sub", 0, 1, T_REG, 3'd0, 7'h20, 32'd3, 32'd10, 6'd22);

    // Hold, then reset mid-stream.
    step("hold.add", 0, 1, T_REG, 3'd0, 7'd0, 32'd1, 32'd1, 6'd9);
    step("hold.idle", 0, 0, T_REG, 3'd4, 7'd0, 32'h1234, 32'h5678, 6'd50);
    check("hold.rlit", bus.result, 32'd2);
    check("hold.dlit", 32'(bus.dest_out), 32'd9);
    step("midrst", 1, 1, T_REG, 3'd0, 7'd0, 32'd8, 32'd8, 6'd12);

    // Randomized traffic across legal and illegal encodings.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 8))
        0: begin op = T_IMM; f3 = 3'd0; end
        1: begin op = T_IMM; f3 = 3'd7; end
        2: begin op = T_REG; f3 = 3'd0; end
        3: begin op = T_REG; f3 = 3'd4; end
        4: begin op = T_REG; f3 = 3'd5; end
        5: begin op = T_LD;  f3 = 3'($urandom); end
        6: begin op = T_ST;  f3 = 3'($urandom); end
        7: begin op = T_REG; f3 = 3'($urandom); end
        default: begin op = 7'($urandom); f3 = 3'($urandom); end
      endcase
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1, 2: f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000 | $urandom_range(0, 1);
      step("rand", ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
           op, f3, f7, a, b, 6'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- Registered integer functional unit for the out-of-order core's issue/fire stage.
- Dispatch drives one fired reservation-station entry per cycle: opcode, func3, func7, two 32-bit operands and the destination physical register.
- The unit returns the computed result, tagged with its destination, one cycle later.
- Three instances exist: FU0 and FU1 handle ALU ops; FU2 handles memory address generation.

Parameters:
- DATA_W, 32, operand/result width.
- PREG_W, 6, physical register tag width (64 physical registers).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  an instruction is being fired this cycle.
- opcode  input  7  RISC-V opcode field.
- func3  input  3  RISC-V funct3 field.
- func7  input  7  RISC-V funct7 field.
- src1  input  DATA_W  operand 1, already read or forwarded by dispatch.
- src2  input  DATA_W  operand 2, or the immediate already extended by dispatch.
- dest_in  input  PREG_W  destination physical register of the fired op.
- out_valid  output  1  result and dest_out are valid.
- dest_out  output  PREG_W  destination tag accompanying the result.
- result  output  DATA_W  computed value.

Behaviour:
- Reset: when rst=1 at a rising edge, out_valid<=0, result<=0, dest_out<=0. Reset overrides any in_valid in the same cycle.
- Latency is exactly 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
- No stall or backpressure. A new op may be accepted every cycle.
- out_valid<=in_valid on every non-reset edge.
- dest_out is registered from dest_in only when in_valid=1.
- result is registered only when in_valid=1. When in_valid=0, result and dest_out hold their previous values.
- Decode (combinational) and result:
  - opcode 0010011, func3 000 (ADDI): src1+src2.
  - opcode 0010011, func3 111 (ANDI): src1 & src2.
  - opcode 0110011, func3 000, func7 0000000 (ADD): src1+src2.
  - opcode 0110011, func3 000, func7 0100000 (SUB): src1-src2.
  - opcode 0110011, func3 100 (XOR): src1 ^ src2; func7 ignored.
  - opcode 0110011, func3 101, func7 0100000 (SRA): signed src1 arithmetically shifted right by src2[4:0]; upper bits of src2 ignored.
  - opcode 0000011 (LW) or 0100011 (SW): src1+src2 (effective address); func3/func7 ignored.
  - Any other opcode/func combination: result 0; out_valid still follows in_valid.
- Arithmetic is modulo 2^32: no overflow flag, carries discarded, no exceptions.
- The ALU does not extend the immediate. src2 is used exactly as supplied.
- The unit is stateless apart from the output registers. No internal queue; back-to-back ops are independent.

Decomposition:
- Shared package (the existing package p):
  - opcode constants OP_IMM=7'b0010011, OP_REG=7'b0110011, OP_LOAD=7'b0000011, OP_STORE=7'b0100011.
  - func3 constants F3_ADD=000, F3_XOR=100, F3_SRA=101, F3_AND=111.
  - func7 constants F7_BASE=0000000, F7_ALT=0100000.
  - PREG_W shared with the rs_row and rob_row typedefs.
- Natural sub-module: alu_core, a purely combinational opcode/func decode plus datapath. alu_unit wraps it with the output register stage and reset.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 and ADD 5+7 -> out_valid=0, result=0, dest_out=0; after release, the same ADD yields result=12 one cycle later.
- ADD/SUB: ADD src1=5, src2=7, dest=33 -> result=0x0000000C, dest_out=33. SUB 5-7 -> result=0xFFFFFFFE. SUB 0x80000000-1 -> 0x7FFFFFFF (wrap).
- Immediates: ADDI src1=0xFFFFFFFF, src2=1 -> 0x00000000. ANDI src1=0x000000FF, src2=0x000000F0 -> 0x000000F0. XOR 0xAAAA5555 ^ 0xFFFF0000 -> 0x55555555.
- SRA: src1=0x80000000, src2=4 -> 0xF8000000. src1=0x40000000, src2=0x24 (only low 5 bits = 4 used) -> 0x04000000.
- Memory/default/back-to-back:
  - LW src1=0x100, src2=0x10 -> 0x110.
  - opcode 1100011 -> result 0, out_valid=1.
  - ADD, XOR, SUB fired on consecutive cycles -> three consecutive valid results, each with its own dest_out.
- Hold: fire ADD 1+1 dest=9, then in_valid=0 -> out_valid drops to 0, result stays 2, dest_out stays 9. Asserting rst mid-stream clears the outputs on the next edge.
